// File: rtl/noc_mux_pkg.sv
// Shared constants and helpers for the registered N:1 router output mux.
package noc_mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Out-of-range selects collapse onto the last input ("1xx -> last" for N=5).
    function automatic int unsigned clamp_sel(input int unsigned s,
                                              input int unsigned n);
        return (s >= n) ? n - 1 : s;
    endfunction

    function automatic int unsigned next_ptr(input int unsigned idx,
                                             input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating-priority encoder with a pointer register.
module rr_arbiter
    import noc_mux_pkg::*;
#(
    parameter int N    = 5,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    logic [SELW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic            found;
        int              j;
        logic [SELW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            idx = SELW'(j);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // Pointer only advances when the grant is actually consumed.
    always_comb begin
        ptr_d = ptr_q;
        if (en && |grant)
            ptr_d = SELW'(next_ptr(int'(grant_idx), N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rr_muxnto1.sv
// Registered N:1 output-port mux with valid/ready, round-robin or fixed
// select arbitration, and a single output register stage.
module rr_muxnto1
    import noc_mux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int N     = 5,
    parameter int SELW  = $clog2(N)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N-1:0]                   in_valid,
    input  logic [N*WIDTH-1:0]             in_data,
    output logic [N-1:0]                   in_ready,
    input  logic                           mode,
    input  logic [((N <= 8) ? 3 : SELW)-1:0] sel,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data,
    output logic [SELW-1:0]                out_src,
    input  logic                           out_ready
);

    logic                 load;
    logic [N-1:0]         rr_grant;
    logic [SELW-1:0]      rr_idx;
    logic [N-1:0]         fx_grant;
    logic [SELW-1:0]      fx_idx;
    logic [N-1:0]         grant;
    logic [SELW-1:0]      grant_idx;
    logic                 have;
    logic [WIDTH-1:0]     sel_data;

    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     data_q,  data_d;
    logic [SELW-1:0]      src_q,   src_d;

    assign load = ~valid_q | out_ready;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .en        (load & (mode == MODE_RR)),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    always_comb begin
        fx_idx           = SELW'(clamp_sel(int'(sel), N));
        fx_grant         = '0;
        fx_grant[fx_idx] = in_valid[fx_idx];
    end

    always_comb begin
        grant     = rr_grant;
        grant_idx = rr_idx;
        if (mode == MODE_FIXED) begin
            grant     = fx_grant;
            grant_idx = fx_idx;
        end
    end

    assign have     = |grant;
    assign in_ready = {N{load}} & grant;
    assign sel_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];

    // No grant on a load cycle empties the register; data/src keep history.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        if (load) begin
            valid_d = have;
            if (have) begin
                data_d = sel_data;
                src_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_rr_muxnto1.sv
// Directed bench for rr_muxnto1 (N=5, WIDTH=8): vector table plus
// hand-written reset sequences.
module tb_rr_muxnto1;

    localparam int N = 5;
    localparam int W = 8;
    localparam int S = $clog2(N);
    localparam int NV = 27;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [2:0]     sel;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_src;
    logic           out_ready;

    int nchk = 0;
    int nfail = 0;

    typedef struct {
        logic [N-1:0] iv;
        logic         m;
        logic [2:0]   sl;
        logic         ordy;
        logic [N-1:0] ir;
        logic         ov;
        logic [2:0]   src;
        logic [7:0]   dat;
    } vec_t;

    vec_t vt[NV];

    always #5 clk = ~clk;

    rr_muxnto1 #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] iv, input logic m,
                                input logic [2:0] sl, input logic ordy,
                                input logic [4:0] ir, input logic ov,
                                input logic [2:0] src, input logic [7:0] dat);
        vec_t v;
        v.iv = iv; v.m = m; v.sl = sl; v.ordy = ordy;
        v.ir = ir; v.ov = ov; v.src = src; v.dat = dat;
        return v;
    endfunction

    initial begin
        // idle with empty register: load is true even with out_ready=0
        vt[0]  = mk(5'b00000, 0, 0, 0, 5'b00000, 0, 0, 8'h00);
        vt[1]  = mk(5'b00000, 0, 0, 0, 5'b00000, 0, 0, 8'h00);
        vt[2]  = mk(5'b00000, 0, 0, 0, 5'b00000, 0, 0, 8'h00);
        // round-robin fairness 0,1,2,3,4,0
        vt[3]  = mk(5'b11111, 0, 0, 0, 5'b00001, 1, 0, 8'hA0);
        vt[4]  = mk(5'b11111, 0, 0, 1, 5'b00010, 1, 1, 8'hA1);
        vt[5]  = mk(5'b11111, 0, 0, 1, 5'b00100, 1, 2, 8'hA2);
        vt[6]  = mk(5'b11111, 0, 0, 1, 5'b01000, 1, 3, 8'hA3);
        vt[7]  = mk(5'b11111, 0, 0, 1, 5'b10000, 1, 4, 8'hA4);
        vt[8]  = mk(5'b11111, 0, 0, 1, 5'b00001, 1, 0, 8'hA0);
        // ptr -> 2, then sparse 10010: grant 4, 1, ptr back at 2
        vt[9]  = mk(5'b11111, 0, 0, 1, 5'b00010, 1, 1, 8'hA1);
        vt[10] = mk(5'b10010, 0, 0, 1, 5'b10000, 1, 4, 8'hA4);
        vt[11] = mk(5'b10010, 0, 0, 1, 5'b00010, 1, 1, 8'hA1);
        vt[12] = mk(5'b11111, 0, 0, 1, 5'b00100, 1, 2, 8'hA2);
        // fixed mode, sel=6 clamps to 4; ptr holds at 3
        vt[13] = mk(5'b11111, 1, 6, 1, 5'b10000, 1, 4, 8'hA4);
        vt[14] = mk(5'b11111, 1, 6, 1, 5'b10000, 1, 4, 8'hA4);
        // sel=2 with input 2 idle: register empties, data/src hold
        vt[15] = mk(5'b11011, 1, 2, 1, 5'b00000, 0, 4, 8'hA4);
        vt[16] = mk(5'b11011, 1, 2, 1, 5'b00000, 0, 4, 8'hA4);
        vt[17] = mk(5'b11111, 0, 0, 1, 5'b01000, 1, 3, 8'hA3);
        // backpressure 4 cycles
        vt[18] = mk(5'b11111, 0, 0, 0, 5'b00000, 1, 3, 8'hA3);
        vt[19] = mk(5'b11111, 0, 0, 0, 5'b00000, 1, 3, 8'hA3);
        vt[20] = mk(5'b11111, 0, 0, 0, 5'b00000, 1, 3, 8'hA3);
        vt[21] = mk(5'b11111, 0, 0, 0, 5'b00000, 1, 3, 8'hA3);
        vt[22] = mk(5'b11111, 0, 0, 1, 5'b10000, 1, 4, 8'hA4);
        vt[23] = mk(5'b11111, 0, 0, 1, 5'b00001, 1, 0, 8'hA0);
        vt[24] = mk(5'b11111, 0, 0, 1, 5'b00010, 1, 1, 8'hA1);
        // fixed sel=0 must not move ptr (still 2)
        vt[25] = mk(5'b11111, 1, 0, 1, 5'b00001, 1, 0, 8'hA0);
        vt[26] = mk(5'b11111, 0, 0, 1, 5'b00100, 1, 2, 8'hA2);

        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
        in_valid  = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_src",   32'(out_src),   0);
        chk("rst_data",  32'(out_data),  0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            in_valid  = vt[i].iv;
            mode      = vt[i].m;
            sel       = vt[i].sl;
            out_ready = vt[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].ov));
            chk($sformatf("v%0d_out_src", i),   32'(out_src),   32'(vt[i].src));
            chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vt[i].dat));
        end

        // reset mid-stream: asynchronous drop between edges
        @(posedge clk);
        #3;
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data",  32'(out_data),  0);
        chk("mid_rst_src",   32'(out_src),   0);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 5'b11111;
        mode      = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h01);
        @(posedge clk);
        #1;
        chk("post_rst_src",   32'(out_src),   0);
        chk("post_rst_data",  32'(out_data),  32'hA0);
        chk("post_rst_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        chk("post_rst_src2",  32'(out_src),   1);
        chk("post_rst_data2", 32'(out_data),  32'hA1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/rr_muxnto1.md
# rr_muxnto1

Parametrised, registered N:1 output-port multiplexer for router datapaths. It generalises the fixed 5:1 select mux to N inputs and adds a valid/ready handshake, round-robin arbitration among requesting inputs, a software-selectable fixed-select mode, and one output register stage. It sits between the input buffers of a router and one output link, and replaces ad-hoc mux-plus-arbiter pairs.

## Interface
- `WIDTH`, default 1: data width per input.
- `N`, default 5: input count; legal range 2..16.
- `SELW`, default `$clog2(N)`: select/source-index width. Never overridden by the instantiator.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset. Assertion is immediate; deassertion is synchronous to `clk`.
- `in_valid`  in  N: per-input request.
- `in_data`  in  N*WIDTH: input i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`  out  N: one-hot or zero; input i is consumed in any cycle where `in_valid[i] & in_ready[i]`.
- `mode`  in  1: 0 = round-robin, 1 = fixed select.
- `sel`  in  3 if N≤8, else SELW: input index used in fixed mode.
- `out_valid`  out  1: output register holds a flit.
- `out_data`  out  WIDTH: registered flit.
- `out_src`  out  SELW: index of the input that supplied `out_data`.
- `out_ready`  in  1: downstream accept.

## Operation
- Load enable: `load = ~out_valid | out_ready`.
- Round-robin mode (`mode`=0):
  - The grant goes to the first asserted `in_valid` found by scanning from pointer `ptr` upward, modulo N.
  - `ptr` becomes (grant+1) mod N, but only on a cycle where a transfer occurs (`load` and a grant both true).
- Fixed mode (`mode`=1):
  - The effective index is `sel` clamped: any `sel` ≥ N maps to N-1. This preserves the "1xx → last input" behaviour for N=5.
  - The grant is the effective index if `in_valid` for that index is set, otherwise none.
  - `ptr` holds its value.
- `in_ready[i] = load & grant[i]`. `in_ready` never depends on `in_valid` of any other input except through the grant.
- On a transfer:
  - `out_data` loads the granted input's data.
  - `out_src` loads the grant index.
  - `out_valid` is set to 1.
- If `load` is true and there is no grant, `out_valid` is set to 0. `out_data` and `out_src` hold their values.
- If `load` is false, all output registers hold.
- A `mode` or `sel` change takes effect for the next grant decision. A flit already registered is unaffected.
- Reset state:
  - `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0.
  - `in_ready` is therefore all-ones-gated by grant, i.e. it follows requests immediately after reset.

## Timing
- Latency is 1 cycle: an input accepted at edge k appears on `out_*` after edge k.
- Full-throughput rule: with `out_ready` held at 1 and requests present, one flit is transferred every cycle.
- Backpressure:
  - With `out_valid`=1 and `out_ready`=0, `in_ready` is all-zero.
  - `out_data` is stable until accepted.
- Simultaneous consume and refill: when `out_valid` and `out_ready` are both 1 and a grant exists, the new flit replaces the old one in the same edge, with no bubble.
- `ptr` wrap-around: a grant to N-1 sets `ptr`=0.
- Reset mid-operation:
  - Any registered flit is discarded.
  - `out_valid` drops asynchronously.
  - Arbitration restarts from input 0.
- Grant and `in_ready` are combinational from `in_valid`, `mode`, `sel`, `ptr`, `out_valid` and `out_ready`. There is no combinational path from `in_data` to any output.

## Structure
- Shared package `noc_mux_pkg` holds:
  - the `MODE_RR` and `MODE_FIXED` constants;
  - a `clamp_sel` function;
  - a `next_ptr` function for modulo-N increment.
- Sub-module `rr_arbiter #(N)`: `clk`, `rst_n`, `req[N]`, `en`, `grant[N]`, `grant_idx[SELW]`. It contains `ptr` and the rotate-priority-encode logic.
- The top level contains:
  - the fixed-mode override;
  - the data select as an indexed part-select or an AND-OR one-hot mux;
  - the output register.

## Test plan
- **Reset and idle:** with N=5, WIDTH=8, hold `rst_n`=0 and then release. Required: `out_valid`=0, `out_src`=0, `out_data`=0. With `in_valid`=0 for 3 cycles, `out_valid` stays 0.
- **Round-robin fairness:** with N=5, `mode`=0, `out_ready`=1, `in_valid`=5'b11111, data i = 8'hA0+i. Required: `out_src` sequence is 0,1,2,3,4,0 on consecutive cycles, with `out_data` A0,A1,A2,A3,A4,A0.
- **Sparse requests:** `in_valid`=5'b10010 with `ptr`=2. Required: grant to input 4 then input 1, and `ptr` ends at 2.
- **Fixed mode and clamp:** `mode`=1, `sel`=3'b110, all inputs valid. Required: every transfer comes from input 4. With `sel`=2 and `in_valid[2]`=0, `out_valid` falls to 0 after one cycle.
- **Backpressure:** `out_ready`=0 for 4 cycles while all inputs are valid. Required: `in_ready`=0, and `out_data` and `out_src` stay constant. Raising `out_ready` produces one flit per cycle with no skipped source.
- **Reset mid-stream:** assert `rst_n`=0 mid-cycle during a full-rate stream. Required: `out_valid`=0 immediately, without waiting for an edge. After release, the first grant goes to input 0.
